// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO depth default, width derivation and pointer wrap helper
package fifo_pkg;

    localparam int DEFAULT_DEPTH = 45;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Wraps at depth-1 rather than at 2^AW so non-power-of-two depths work.
    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_addr_gen_cmp.sv
// rtl/fifo_addr_gen_cmp.sv - full/empty comparator from pointers and direction
module fifo_addr_gen_cmp
    import fifo_pkg::*;
#(
    parameter int DATADEPTH = DEFAULT_DEPTH,
    localparam int AW = addr_width(DATADEPTH)
) (
    input  logic [AW-1:0] B_W_address,
    input  logic [AW-1:0] B_R_address,
    input  logic          direction,
    output logic          afull,
    output logic          aempty
);

    logic equal;

    // Equal pointers are ambiguous; direction says which way the FIFO was heading.
    assign equal  = (B_W_address == B_R_address);
    assign afull  = equal && direction;
    assign aempty = equal && !direction;

endmodule

// File: rtl/fifo_addr_gen.sv
// rtl/fifo_addr_gen.sv - single-clock FIFO pointer, direction, count and error-flag generator
module fifo_addr_gen
    import fifo_pkg::*;
#(
    parameter int DATADEPTH = DEFAULT_DEPTH,
    localparam int AW = addr_width(DATADEPTH),
    localparam int CW = addr_width(DATADEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_en,
    input  logic          r_en,
    output logic [AW-1:0] B_W_address,
    output logic [AW-1:0] B_R_address,
    output logic          direction,
    output logic          full,
    output logic          empty,
    output logic          w_ack,
    output logic          r_ack,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    assign w_ack = w_en && !full;
    assign r_ack = r_en && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            B_W_address <= '0;
            B_R_address <= '0;
            direction   <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            overflow  <= w_en && full;
            underflow <= r_en && empty;
            if (w_ack)
                B_W_address <= AW'(ptr_next(32'(B_W_address), DATADEPTH));
            if (r_ack)
                B_R_address <= AW'(ptr_next(32'(B_R_address), DATADEPTH));
            if (w_ack && !r_ack) begin
                direction <= 1'b1;
                count     <= count + CW'(1);
            end else if (r_ack && !w_ack) begin
                direction <= 1'b0;
                count     <= count - CW'(1);
            end
        end
    end

    fifo_addr_gen_cmp #(
        .DATADEPTH(DATADEPTH)
    ) u_cmp (
        .B_W_address(B_W_address),
        .B_R_address(B_R_address),
        .direction  (direction),
        .afull      (full),
        .aempty     (empty)
    );

endmodule

// File: tb/tb_fifo_addr_gen.sv
// tb/tb_fifo_addr_gen.sv - self-checking bench for fifo_addr_gen against an occupancy model
module tb_fifo_addr_gen;

    localparam int D = 45;
    localparam int AW = $clog2(D);
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic          r_en = 1'b0;
    logic [AW-1:0] B_W_address;
    logic [AW-1:0] B_R_address;
    logic          direction;
    logic          full;
    logic          empty;
    logic          w_ack;
    logic          r_ack;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    // Model: totals of accepted writes/reads; addresses are totals mod depth.
    int m_wt = 0;
    int m_rt = 0;
    int m_dir = 0;
    int m_ov = 0;
    int m_un = 0;

    fifo_addr_gen #(.DATADEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .w_en       (w_en),
        .r_en       (r_en),
        .B_W_address(B_W_address),
        .B_R_address(B_R_address),
        .direction  (direction),
        .full       (full),
        .empty      (empty),
        .w_ack      (w_ack),
        .r_ack      (r_ack),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int occ;
        bit wa, ra;
        occ = m_wt - m_rt;
        if (rst) begin
            m_wt = 0; m_rt = 0; m_dir = 0; m_ov = 0; m_un = 0;
        end else begin
            wa = w_en && (occ != D);
            ra = r_en && (occ != 0);
            m_ov = (w_en && occ == D) ? 1 : 0;
            m_un = (r_en && occ == 0) ? 1 : 0;
            if (wa) m_wt++;
            if (ra) m_rt++;
            if (wa && !ra) m_dir = 1;
            if (ra && !wa) m_dir = 0;
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        int occ;
        if (started) begin
            occ = m_wt - m_rt;
            chk("m_waddr", int'(B_W_address), m_wt % D);
            chk("m_raddr", int'(B_R_address), m_rt % D);
            chk("m_dir", int'(direction), m_dir);
            chk("m_count", int'(count), occ);
            chk("m_full", int'(full), (occ == D) ? 1 : 0);
            chk("m_empty", int'(empty), (occ == 0) ? 1 : 0);
            chk("m_w_ack", int'(w_ack), (w_en && occ != D) ? 1 : 0);
            chk("m_r_ack", int'(r_ack), (r_en && occ != 0) ? 1 : 0);
            chk("m_overflow", int'(overflow), m_ov);
            chk("m_underflow", int'(underflow), m_un);
        end
    end

    task automatic drive(input bit w, input bit r, input bit rs);
        w_en = w;
        r_en = r;
        rst  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic state_is(input string tag, input int wa, input int ra, input int dir,
                            input int cnt, input int fu, input int em);
        chk({tag, "_waddr"}, int'(B_W_address), wa);
        chk({tag, "_raddr"}, int'(B_R_address), ra);
        chk({tag, "_dir"}, int'(direction), dir);
        chk({tag, "_count"}, int'(count), cnt);
        chk({tag, "_full"}, int'(full), fu);
        chk({tag, "_empty"}, int'(empty), em);
    endtask

    initial begin
        drive(0, 0, 1);
        drive(0, 0, 1);
        state_is("reset0", 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < 40; i++)
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        drive(0, 0, 1);
        state_is("reset1", 0, 0, 0, 0, 0, 1);
        chk("reset1_ovf", int'(overflow), 0);
        chk("reset1_unf", int'(underflow), 0);

        for (int i = 0; i < D; i++) begin
            chk("fill_step", int'(B_W_address), i);
            drive(1, 0, 0);
        end
        state_is("full", 0, 0, 1, 45, 1, 0);
        w_en = 1'b1; #1;
        chk("full_w_ack", int'(w_ack), 0);
        drive(1, 0, 0);
        chk("full_ovf", int'(overflow), 1);
        state_is("full_rej", 0, 0, 1, 45, 1, 0);
        drive(0, 0, 0);
        chk("full_ovf_drop", int'(overflow), 0);

        for (int i = 0; i < D; i++) drive(0, 1, 0);
        state_is("drained", 0, 0, 0, 0, 0, 1);
        r_en = 1'b1; #1;
        chk("empty_r_ack", int'(r_ack), 0);
        drive(0, 1, 0);
        chk("empty_unf", int'(underflow), 1);
        drive(0, 0, 0);
        chk("empty_unf_drop", int'(underflow), 0);

        for (int i = 0; i < 10; i++) drive(1, 0, 0);
        for (int i = 0; i < 50; i++) drive(1, 1, 0);
        state_is("concurrent", 15, 5, 1, 10, 0, 0);
        chk("concurrent_ovf", int'(overflow), 0);
        chk("concurrent_unf", int'(underflow), 0);

        for (int i = 0; i < 10; i++) drive(0, 1, 0);
        state_is("empty_again", 15, 15, 0, 0, 0, 1);
        drive(1, 1, 0);
        state_is("both_empty", 16, 15, 1, 1, 0, 0);
        chk("both_empty_unf", int'(underflow), 1);
        for (int i = 0; i < 44; i++) drive(1, 0, 0);
        state_is("full_again", 15, 15, 1, 45, 1, 0);
        drive(1, 1, 0);
        state_is("both_full", 15, 16, 0, 44, 0, 0);
        chk("both_full_ovf", int'(overflow), 1);

        drive(0, 0, 1);
        for (int i = 0; i < 20; i++) drive(1, 0, 0);
        chk("pre_rst_count", int'(count), 20);
        drive(1, 0, 1);
        state_is("rst_mid", 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0);
        state_is("rst_mid_hold", 0, 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_addr_gen.md
Name: fifo_addr_gen

Overview:
- Single-clock FIFO pointer generator. Produces the binary write/read addresses and the direction flag consumed by the existing comparator block.
- Owns pointer advance, wrap-around at a non-power-of-two depth, direction tracking, occupancy count and error flags.
- Sits between the FIFO user handshake (w_en/r_en) and the dual-port storage array.

Parameters:
- DATADEPTH, 45, number of FIFO entries; any value >= 2, power of two not required.
- AW, $clog2(DATADEPTH), address width (derived localparam, not overridable).
- CW, $clog2(DATADEPTH+1), count width (derived localparam).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request from producer.
- r_en  in  1  read request from consumer.
- B_W_address  out  AW  current write address to storage array and comparator.
- B_R_address  out  AW  current read address to storage array and comparator.
- direction  out  1  1 = last pointer-changing event was write-only (heading full); 0 = read-only (heading empty).
- full  out  1  from comparator afull.
- empty  out  1  from comparator aempty.
- w_ack  out  1  combinational, w_en && !full: write accepted this cycle.
- r_ack  out  1  combinational, r_en && !empty: read accepted this cycle.
- count  out  CW  registered occupancy, 0..DATADEPTH.
- overflow  out  1  registered one-cycle pulse: w_en while full.
- underflow  out  1  registered one-cycle pulse: r_en while empty.

Behaviour:
- Reset (rst=1 at an edge): B_W_address=0, B_R_address=0, direction=0, count=0, overflow=0, underflow=0. Hence empty=1, full=0. Reset overrides every other input, including mid-transfer; no partial state is retained.
- Write acceptance: w_ack = w_en && !full. Read acceptance: r_ack = r_en && !empty. Both are evaluated on pre-edge state.
- Pointer advance: on accepted access, pointer <= (pointer == DATADEPTH-1) ? 0 : pointer+1. Never use modulo-2^AW wrap.
- Direction:
  - w_ack && !r_ack -> direction <= 1.
  - r_ack && !w_ack -> direction <= 0.
  - Both or neither -> direction holds.
- Count: +1 on write-only, -1 on read-only, hold otherwise. Invariant: count == DATADEPTH iff full; count == 0 iff empty.
- Simultaneous w_en && r_en:
  - Normal occupancy: both accepted; count and direction unchanged.
  - Full: read accepted, write rejected, overflow pulses.
  - Empty: write accepted, read rejected, underflow pulses.
- Latency: addresses, count and direction reflect an access one cycle after the accepting edge. full/empty follow combinationally from the registered pointers, so they are also one cycle after the edge.
- Rejected requests leave all pointer, count and direction state unchanged.
- overflow/underflow are single-cycle pulses; no sticky state.

Decomposition:
- Shared package fifo_pkg: DATADEPTH default, AW/CW derivation function, pointer-increment-with-wrap function. The function is shared with any future dual-clock variant.
- One sub-module: instantiate the existing comparator with DATADEPTH passed through. It generates full/empty from B_W_address, B_R_address and direction; do not duplicate its equality logic.

Test Plan (DATADEPTH=45, AW=6, CW=6):
- Reset: rst=1 for 1 cycle after random traffic -> next cycle addresses 0, direction 0, count 0, empty 1, full 0, no error pulses.
- Fill: 45 consecutive w_en -> B_W_address steps 0..44 then wraps to 0, direction 1, full 1, count 45. 46th w_en -> w_ack 0, overflow pulses one cycle, pointers unchanged.
- Drain from full: 45 consecutive r_en -> B_R_address wraps 44->0, direction 0, empty 1, count 0. Extra r_en -> r_ack 0, underflow pulse.
- Concurrent mid-level: count=10, w_en=r_en=1 for 50 cycles -> both pointers wrap, count stays 10, direction unchanged, no errors.
- Concurrent at boundaries:
  - Empty + w_en=r_en=1 -> write only, count 1, direction 1, underflow pulse.
  - Full + both -> read only, count 44, direction 0, overflow pulse.
- Reset mid-operation: count=20, w_en=1 with rst=1 on same edge -> all state zero next cycle; the write is not performed.
